// File: rtl/seq_div.sv
// Sequential unsigned restoring divider: one quotient bit per clock, MSB first.
// The trial subtraction is a ripple chain of fa cells; its carry-out is the
// "no borrow" decision for the current quotient bit.

// One-bit full adder cell used to build the trial subtractor.
module fa (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

// state | meaning
// IDLE  | waiting for start; results hold last values
// RUN   | one restoring-division iteration per clock, counter counts down
// DONE  | results valid, done=1 for this single cycle
module seq_div #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] prem_q, prem_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             dbz_q, dbz_d;

    // Shifted partial remainder minus divisor: a + ~b + 1 over WIDTH+1 bits.
    logic [WIDTH:0]   trial_a;
    logic [WIDTH:0]   trial_b;
    logic [WIDTH:0]   trial_s;
    logic [WIDTH+1:0] carry;
    logic             no_borrow;
    logic             unused_diff_msb;

    assign trial_a  = {prem_q, shreg_q[WIDTH-1]};
    assign trial_b  = ~{1'b0, dvs_q};
    assign carry[0] = 1'b1;

    for (genvar i = 0; i <= WIDTH; i++) begin : g_sub
        fa u_fa (
            .a  (trial_a[i]),
            .b  (trial_b[i]),
            .ci (carry[i]),
            .s  (trial_s[i]),
            .co (carry[i+1])
        );
    end

    assign no_borrow = carry[WIDTH+1];
    // With no borrow the difference is below the divisor, so its MSB is always 0.
    assign unused_diff_msb = trial_s[WIDTH];

    // Next-state and datapath update for IDLE/RUN/DONE.
    always_comb begin
        state_d = state_q;
        prem_d  = prem_q;
        shreg_d = shreg_q;
        dvs_d   = dvs_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        dbz_d   = dbz_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (divisor != '0) begin
                        state_d = RUN;
                        prem_d  = '0;
                        shreg_d = dividend;
                        dvs_d   = divisor;
                        cnt_d   = CW'(WIDTH);
                        busy_d  = 1'b1;
                    end else begin
                        state_d = DONE;
                        quot_d  = '1;
                        rem_d   = dividend;
                        dbz_d   = 1'b1;
                        done_d  = 1'b1;
                    end
                end
            end
            RUN: begin
                shreg_d = {shreg_q[WIDTH-2:0], no_borrow};
                prem_d  = no_borrow ? trial_s[WIDTH-1:0] : trial_a[WIDTH-1:0];
                cnt_d   = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = DONE;
                    quot_d  = shreg_d;
                    rem_d   = prem_d;
                    dbz_d   = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State, datapath and registered outputs; reset clears everything at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            prem_q  <= '0;
            shreg_q <= '0;
            dvs_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            prem_q  <= prem_d;
            shreg_q <= shreg_d;
            dvs_q   <= dvs_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
        end
    end

    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;
endmodule
